// File: rtl/mnist_run_ctrl.sv
// Board-level run controller for the MNIST accelerator: debounced start button and image select,
// single-cycle start, result capture/hold, bad-selection and timeout flags.
module mnist_run_ctrl #(
  parameter int DBNC_CYCLES    = 250000,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int NUM_IMGS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic [1:0] sw_sel,
  output logic       acc_start,
  output logic [1:0] acc_sel,
  input  logic       acc_done,
  input  logic [3:0] acc_digit,
  output logic [3:0] res_digit,
  output logic       res_valid,
  output logic       busy,
  output logic       err_sel,
  output logic       err_timeout,
  output logic [7:0] run_cnt
);

  localparam int DW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DBNC_LAST  = DW'(DBNC_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    NUM_IMGS_W = 3'(NUM_IMGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bit 0 is the button, bits 2:1 are the select switches.
  logic [2:0]         meta_r, sync_r, deb_r;
  logic [2:0][DW-1:0] dbnc_cnt_r;
  logic               btn_prev_r;
  logic               press_s, sel_bad_s;

  state_t        state_r, state_nxt;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    res_digit_nxt;
  logic          res_valid_nxt, err_sel_nxt, err_tmo_nxt;
  logic [7:0]    run_cnt_nxt;

  // Two-flop synchronisers on all raw inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 3'b000;
      sync_r <= 3'b000;
    end else begin
      meta_r <= {sw_sel, btn_start};
      sync_r <= meta_r;
    end
  end

  // Per-input debounce: accept a new level only after it holds for DBNC_CYCLES cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_r      <= 3'b000;
      dbnc_cnt_r <= '0;
      btn_prev_r <= 1'b0;
    end else begin
      btn_prev_r <= deb_r[0];
      for (int i = 0; i < 3; i++) begin
        if (sync_r[i] == deb_r[i]) begin
          dbnc_cnt_r[i] <= '0;
        end else if (dbnc_cnt_r[i] == DBNC_LAST) begin
          deb_r[i]      <= sync_r[i];
          dbnc_cnt_r[i] <= '0;
        end else begin
          dbnc_cnt_r[i] <= dbnc_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  assign press_s   = deb_r[0] & ~btn_prev_r;
  assign sel_bad_s = ({1'b0, deb_r[2:1]} >= NUM_IMGS_W);

  // Next-state and next-output logic of the run FSM
  always_comb begin
    state_nxt     = state_r;
    tmo_cnt_nxt   = tmo_cnt_r;
    sel_nxt       = acc_sel;
    res_digit_nxt = res_digit;
    res_valid_nxt = res_valid;
    err_sel_nxt   = err_sel;
    err_tmo_nxt   = err_timeout;
    run_cnt_nxt   = run_cnt;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          if (sel_bad_s) begin
            err_sel_nxt = 1'b1;
          end else begin
            sel_nxt       = deb_r[2:1];
            err_sel_nxt   = 1'b0;
            err_tmo_nxt   = 1'b0;
            res_valid_nxt = 1'b0;
            state_nxt     = START;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        tmo_cnt_nxt = '0;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // Done has priority over a timeout expiring in the same cycle.
        if (acc_done) begin
          res_digit_nxt = acc_digit;
          res_valid_nxt = 1'b1;
          run_cnt_nxt   = run_cnt + 8'd1;
          state_nxt     = DRAIN;
        end else if (tmo_cnt_r == TMO_LAST) begin
          err_tmo_nxt = 1'b1;
          state_nxt   = DRAIN;
        end else begin
          tmo_cnt_nxt = tmo_cnt_r + TW'(1);
        end
      end
      DRAIN: begin
        if (!acc_done) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= '0;
      acc_start   <= 1'b0;
      acc_sel     <= 2'b00;
      res_digit   <= 4'd0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
      run_cnt     <= 8'd0;
    end else begin
      state_r     <= state_nxt;
      tmo_cnt_r   <= tmo_cnt_nxt;
      acc_start   <= (state_nxt == START);
      acc_sel     <= sel_nxt;
      res_digit   <= res_digit_nxt;
      res_valid   <= res_valid_nxt;
      busy        <= (state_nxt != IDLE);
      err_sel     <= err_sel_nxt;
      err_timeout <= err_tmo_nxt;
      run_cnt     <= run_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mnist_run_ctrl.sv
// Scoreboard bench for mnist_run_ctrl: stimulus pushes expected start/result entries,
// a negedge monitor pops and compares on acc_start pulses and busy falling edges.
module tb_mnist_run_ctrl;

  logic       clk, rst, btn_start, acc_done;
  logic [1:0] sw_sel, acc_sel;
  logic [3:0] acc_digit, res_digit;
  logic       acc_start, res_valid, busy, err_sel, err_timeout;
  logic [7:0] run_cnt;

  mnist_run_ctrl #(.DBNC_CYCLES(4), .TIMEOUT_CYCLES(50), .NUM_IMGS(3)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .sw_sel(sw_sel),
    .acc_start(acc_start), .acc_sel(acc_sel), .acc_done(acc_done), .acc_digit(acc_digit),
    .res_digit(res_digit), .res_valid(res_valid), .busy(busy), .err_sel(err_sel),
    .err_timeout(err_timeout), .run_cnt(run_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] digit;
    logic       tmo;
    logic [7:0] cnt;
    int         lat;
  } res_t;

  logic [1:0] start_q[$];
  res_t       res_q[$];
  int         checks = 0;
  int         failures = 0;

  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] exp_digit = 4'd0;

  // accelerator model configuration
  logic       acc_en = 1'b0;
  int         done_delay = 20;
  int         done_hold = 3;
  logic [3:0] digit_cfg = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic expect_run(input logic [1:0] sel, input logic ok, input logic [3:0] dig,
                            input int lat);
    res_t r;
    start_q.push_back(sel);
    if (ok) begin
      exp_cnt   = exp_cnt + 8'd1;
      exp_digit = dig;
    end
    r.valid = ok;
    r.digit = exp_digit;
    r.tmo   = ~ok;
    r.cnt   = exp_cnt;
    r.lat   = lat;
    res_q.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    btn_start = 1'b1;
    idle(n);
    btn_start = 1'b0;
    idle(8);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while ((start_q.size() != 0 || res_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=busy/pending expected=idle_within_%0d", name, maxc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_acc_start"}, 32'(acc_start), 0);
    chk({name, "_acc_sel"}, 32'(acc_sel), 0);
    chk({name, "_res_digit"}, 32'(res_digit), 0);
    chk({name, "_res_valid"}, 32'(res_valid), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_err_sel"}, 32'(err_sel), 0);
    chk({name, "_err_timeout"}, 32'(err_timeout), 0);
    chk({name, "_run_cnt"}, 32'(run_cnt), 0);
  endtask

  // Accelerator model: raises done done_delay cycles after seeing acc_start
  initial begin
    acc_done  = 1'b0;
    acc_digit = 4'd0;
    forever begin
      @(negedge clk);
      if (acc_start && acc_en) begin
        repeat (done_delay) @(negedge clk);
        acc_done  = 1'b1;
        acc_digit = digit_cfg;
        repeat (done_hold) @(negedge clk);
        acc_done  = 1'b0;
      end
    end
  end

  // Monitor: compare on start pulses and at the end of each run
  int         cyc = 0;
  int         start_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [1:0] mon_sel;
  res_t       mon_res;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      busy_prev = 1'b0;
    end else begin
      if (acc_start) begin
        start_cyc = cyc;
        if (start_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_acc_start actual=1 expected=0 at_cycle=%0d", cyc);
        end else begin
          mon_sel = start_q.pop_front();
          chk("acc_sel_at_start", 32'(acc_sel), 32'(mon_sel));
        end
      end
      if (busy_prev && !busy) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_run_end actual=1 expected=0 at_cycle=%0d", cyc);
        end else begin
          mon_res = res_q.pop_front();
          chk("res_valid", 32'(res_valid), 32'(mon_res.valid));
          chk("res_digit", 32'(res_digit), 32'(mon_res.digit));
          chk("err_timeout", 32'(err_timeout), 32'(mon_res.tmo));
          chk("run_cnt", 32'(run_cnt), 32'(mon_res.cnt));
          if (mon_res.lat >= 0) chk("run_latency", cyc - start_cyc, mon_res.lat);
        end
      end
      busy_prev = busy;
    end
  end

  logic [11:0] bounce;

  initial begin
    rst = 1'b0;
    btn_start = 1'b0;
    sw_sel = 2'd0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b1;
    idle(5);

    // 1: clean press, sel=1, digit 2 after 20 cycles
    sw_sel = 2'd1; acc_en = 1'b1; done_delay = 20; done_hold = 3; digit_cfg = 4'd2;
    idle(10);
    expect_run(2'd1, 1'b1, 4'd2, -1);
    press(10);
    wait_done("t1", 200);

    // 2: bouncing button then steady high -> one run
    sw_sel = 2'd2; digit_cfg = 4'd7;
    idle(10);
    expect_run(2'd2, 1'b1, 4'd7, -1);
    bounce = 12'b1011_0100_1101;
    for (int i = 0; i < 12; i++) begin
      btn_start = bounce[i];
      @(negedge clk);
    end
    press(10);
    wait_done("t2", 200);

    // 3: illegal select, then legal one clears err_sel
    sw_sel = 2'd3;
    idle(10);
    press(10);
    chk("t3_err_sel_set", 32'(err_sel), 1);
    chk("t3_busy_idle", 32'(busy), 0);
    sw_sel = 2'd0; digit_cfg = 4'd5;
    idle(10);
    expect_run(2'd0, 1'b1, 4'd5, -1);
    press(10);
    chk("t3_err_sel_clear", 32'(err_sel), 0);
    wait_done("t3", 200);

    // 4a: no done -> timeout after 50 WAIT cycles, digit held
    sw_sel = 2'd1; acc_en = 1'b0;
    idle(10);
    expect_run(2'd1, 1'b0, 4'd0, 52);
    press(10);
    wait_done("t4a", 200);
    // 4b: done arrives in the cycle the timeout would fire
    acc_en = 1'b1; done_delay = 50; done_hold = 2; digit_cfg = 4'd9;
    expect_run(2'd1, 1'b1, 4'd9, -1);
    press(10);
    wait_done("t4b", 200);

    // 5: second press and switch change during WAIT are ignored; long done
    done_delay = 30; done_hold = 5; digit_cfg = 4'd4;
    expect_run(2'd1, 1'b1, 4'd4, -1);
    press(10);
    sw_sel = 2'd2;
    press(10);
    chk("t5_busy_during_2nd_press", 32'(busy), 1);
    wait_done("t5", 200);
    chk("t5_acc_sel_held", 32'(acc_sel), 1);
    idle(10);
    chk("t5_run_cnt_single", 32'(run_cnt), 32'(exp_cnt));

    // 6a: reset in WAIT clears everything immediately
    sw_sel = 2'd1; acc_en = 1'b0;
    idle(10);
    start_q.push_back(2'd1);
    press(10);
    chk("t6_busy_before_reset", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'd0; exp_digit = 4'd0;
    chk("t6_start_popped", start_q.size(), 0);
    idle(10);

    // 6b: 256 completed runs wrap run_cnt to 0
    acc_en = 1'b1; done_delay = 1; done_hold = 1;
    for (int i = 0; i < 256; i++) begin
      digit_cfg = 4'(i % 10);
      expect_run(2'd1, 1'b1, 4'(i % 10), -1);
      press(8);
      wait_done("t6_wrap", 100);
    end
    chk("t6_run_cnt_wrap", 32'(run_cnt), 0);
    chk("final_start_q_empty", start_q.size(), 0);
    chk("final_res_q_empty", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
